io_sequencer: RTL and testbench
===============================

IO_SEQUENCER -- requirements
Module: io_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: processor data width.
REQ-002 Parameter DISP_TIMEOUT, default 255: maximum wait cycles for display acknowledge.
REQ-003 Clock  input  1  single clock; all state changes on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high; forces reset state immediately.
REQ-005 IO_Enable  input  1  current instruction is an IO operation.
REQ-006 IO_Selection  input  2  operation select: 0 OUT, 1 IN, 2 GETC, 3 display write.
REQ-007 Halt  input  1  current instruction is HALT.
REQ-008 Write_Data  input  DATA_WIDTH  register operand for OUT and display writes.
REQ-009 Stall  output  1  freeze PC and pipeline while high.
REQ-010 Read_Data  output  DATA_WIDTH  captured IN/GETC value for register writeback.
REQ-011 Read_Valid  output  1  one-cycle pulse; Read_Data valid for writeback.
REQ-012 Halted  output  1  processor halted.
REQ-013 Timeout_Err  output  1  sticky display-timeout flag.
REQ-014 Out_Data  output  DATA_WIDTH  OUT value, registered.
REQ-015 Out_Valid  output  1  one-cycle OUT strobe.
REQ-016 In_Data  input  DATA_WIDTH  switch input value.
REQ-017 In_Confirm  input  1  level from the confirm button; already debounced.
REQ-018 Key_Data  input  8  keyboard character.
REQ-019 Key_Valid  input  1  character available.
REQ-020 Key_Ack  output  1  one-cycle pulse; character consumed.
REQ-021 Disp_Data  output  DATA_WIDTH  display write payload, registered.
REQ-022 Disp_Req  output  1  display request; held until acknowledge or timeout.
REQ-023 Disp_Ack  input  1  display accepted the request.

Function
REQ-024 States SHALL be IDLE, OUT_PULSE, WAIT_IN, WAIT_KEY, WAIT_DISP, DONE and HALTED.
REQ-025 In IDLE, Halt=1 SHALL transition to HALTED, and Halt SHALL take priority over IO_Enable.
REQ-026 In IDLE with Halt=0 and IO_Enable=1, the block SHALL latch Write_Data and go to OUT_PULSE, WAIT_IN, WAIT_KEY or WAIT_DISP according to IO_Selection 0, 1, 2 or 3.
REQ-027 Stall SHALL be combinational: high in IDLE when IO_Enable=1 or Halt=1; high in OUT_PULSE, WAIT_IN, WAIT_KEY, WAIT_DISP and HALTED; low in DONE.
REQ-028 OUT_PULSE SHALL drive Out_Valid=1 for exactly one cycle, with Out_Data equal to the latched value, then go to DONE.
REQ-029 OUT latency SHALL be: accept cycle, pulse cycle, DONE cycle, so Stall is high for exactly 2 cycles.
REQ-030 The block SHALL register In_Confirm every cycle, and the confirm edge SHALL be In_Confirm & ~In_Confirm_q.
REQ-031 Confirm edges occurring outside WAIT_IN SHALL be discarded.
REQ-032 In WAIT_IN, a confirm edge SHALL capture In_Data into Read_Data and go to DONE.
REQ-033 In WAIT_KEY, Key_Valid=1 SHALL capture Key_Data zero-extended into Read_Data, pulse Key_Ack for one cycle, and go to DONE.
REQ-034 Key_Valid already high on the first WAIT_KEY cycle SHALL be accepted on that cycle.
REQ-035 In WAIT_DISP, Disp_Req SHALL be 1 and Disp_Data SHALL be stable.
REQ-036 In WAIT_DISP, a timeout counter SHALL start at 0 on entry and increment each cycle Disp_Ack=0.
REQ-037 In WAIT_DISP, Disp_Ack=1 SHALL go to DONE.
REQ-038 In WAIT_DISP, a counter value of DISP_TIMEOUT SHALL set Timeout_Err and go to DONE, with Disp_Ack taking priority on the same cycle.
REQ-039 Disp_Req SHALL be low in every state other than WAIT_DISP.
REQ-040 DONE SHALL last one cycle, then go to IDLE.
REQ-041 In DONE, Read_Valid SHALL be 1 only if the completed operation was IN or GETC.
REQ-042 Read_Data SHALL hold its value until the next capture.
REQ-043 HALTED SHALL drive Halted=1 and Stall=1, and SHALL be left only by Reset.
REQ-044 IO_Enable and IO_Selection SHALL be ignored in every state except IDLE.
REQ-045 Timeout_Err SHALL be cleared only by Reset.

Reset
REQ-046 On Reset=1, state SHALL be IDLE immediately, regardless of the clock.
REQ-047 Reset SHALL clear Read_Data, Out_Data, Disp_Data, the timeout counter and In_Confirm_q to 0.
REQ-048 Reset SHALL drive Read_Valid, Out_Valid, Key_Ack, Disp_Req, Halted and Timeout_Err to 0.
REQ-049 Reset asserted during any WAIT state SHALL abort the operation with no Read_Valid and no Key_Ack pulse, and SHALL drop Disp_Req in the same cycle.

Verification
REQ-050 OUT: IO_Enable=1, sel=0, Write_Data=0x1234 -> Out_Valid pulses once with Out_Data=0x1234, Stall high 2 cycles, no Read_Valid.
REQ-051 IN: sel=1, In_Confirm held high before entry, then low, then rising with In_Data=0xABCD -> first edge ignored; after the new edge Read_Data=0xABCD and Read_Valid pulses once.
REQ-052 GETC: sel=2, Key_Valid rises after 5 cycles with Key_Data=0x41 -> Key_Ack one pulse, Read_Data=0x00000041, Read_Valid one pulse.
REQ-053 Display timeout: DISP_TIMEOUT=4, sel=3, Disp_Ack=0 -> Disp_Req high 5 cycles, Timeout_Err=1, DONE, then IDLE; Disp_Ack on the final counter cycle leaves Timeout_Err=0.
REQ-054 Halt priority: Halt=1 and IO_Enable=1 in IDLE -> HALTED, Stall=1, Halted=1, no device strobes.
REQ-055 Reset mid-wait: Reset asserted in WAIT_DISP and in HALTED -> asynchronous return to IDLE, Disp_Req=0, Halted=0, Stall=0.

Source files
------------

// File: rtl/io_sequencer_if.sv
// Purpose: bundles the processor-side IO handshake and the switch/keyboard/display device pins of io_sequencer.
// Latency: none; this file declares wires only.
// Backpressure: none; the sequencer asserts stall toward the processor, and the devices answer through key_valid/disp_ack.
// Ports: master = processor + device models, slave = sequencer.
interface io_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    // processor side
    logic                  io_enable;
    logic [1:0]            io_sel;
    logic                  halt;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  stall;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;
    logic                  halted;
    logic                  timeout_err;
    // OUT port
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    // switches + confirm button
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_confirm;
    // keyboard
    logic [7:0]            key_data;
    logic                  key_valid;
    logic                  key_ack;
    // display
    logic [DATA_WIDTH-1:0] disp_data;
    logic                  disp_req;
    logic                  disp_ack;

    modport master (
        output io_enable, io_sel, halt, write_data, in_data, in_confirm,
               key_data, key_valid, disp_ack,
        input  stall, read_data, read_valid, halted, timeout_err, out_data,
               out_valid, key_ack, disp_data, disp_req
    );

    modport slave (
        input  io_enable, io_sel, halt, write_data, in_data, in_confirm,
               key_data, key_valid, disp_ack,
        output stall, read_data, read_valid, halted, timeout_err, out_data,
               out_valid, key_ack, disp_data, disp_req
    );
endinterface

// File: rtl/io_sequencer.sv
// Purpose: sequences one processor IO instruction (OUT, IN, GETC, display write) or HALT, stalling the pipeline meanwhile.
// Latency: OUT stalls 2 cycles; IN/GETC/display stall until the device answers, and the display gives up after DISP_TIMEOUT cycles.
// Backpressure: stall holds the processor; the keyboard is acked with key_ack; disp_req is held until disp_ack or timeout.
// Ports: clk_i, rst_i (async, active-high); bus = io_sequencer_if.slave carrying all processor and device signals.
module io_sequencer #(
    parameter int DATA_WIDTH   = 32,
    parameter int DISP_TIMEOUT = 255
) (
    input  logic           clk_i,
    input  logic           rst_i,
    io_sequencer_if.slave  bus
);
    localparam int CNT_W = (DISP_TIMEOUT < 1) ? 1 : $clog2(DISP_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OUT_PULSE,
        S_WAIT_IN,
        S_WAIT_KEY,
        S_WAIT_DISP,
        S_DONE,
        S_HALTED
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DATA_WIDTH-1:0] disp_data_q, disp_data_d;
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                  rd_op_q, rd_op_d;        // completed op writes a register
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  confirm_q;

    logic stall, out_valid, read_valid, key_ack, disp_req, halted;
    logic confirm_edge;

    // Tracked every cycle so a press made before WAIT_IN cannot count as a new edge.
    assign confirm_edge = bus.in_confirm & ~confirm_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            out_data_q    <= '0;
            disp_data_q   <= '0;
            read_data_q   <= '0;
            rd_op_q       <= 1'b0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
            confirm_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_data_q    <= out_data_d;
            disp_data_q   <= disp_data_d;
            read_data_q   <= read_data_d;
            rd_op_q       <= rd_op_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            confirm_q     <= bus.in_confirm;
        end
    end

    always_comb begin
        state_d       = state_q;
        out_data_d    = out_data_q;
        disp_data_d   = disp_data_q;
        read_data_d   = read_data_q;
        rd_op_d       = rd_op_q;
        cnt_d         = '0;              // counter restarts from 0 on every WAIT_DISP entry
        timeout_err_d = timeout_err_q;
        stall         = 1'b0;
        out_valid     = 1'b0;
        read_valid    = 1'b0;
        key_ack       = 1'b0;
        disp_req      = 1'b0;
        halted        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.halt) begin
                    stall   = 1'b1;
                    state_d = S_HALTED;
                end else if (bus.io_enable) begin
                    stall   = 1'b1;
                    rd_op_d = (bus.io_sel == 2'd1) || (bus.io_sel == 2'd2);
                    case (bus.io_sel)
                        2'd0: begin
                            out_data_d = bus.write_data;
                            state_d    = S_OUT_PULSE;
                        end
                        2'd1: state_d = S_WAIT_IN;
                        2'd2: state_d = S_WAIT_KEY;
                        default: begin
                            disp_data_d = bus.write_data;
                            state_d     = S_WAIT_DISP;
                        end
                    endcase
                end
            end
            S_OUT_PULSE: begin
                stall     = 1'b1;
                out_valid = 1'b1;
                state_d   = S_DONE;
            end
            S_WAIT_IN: begin
                stall = 1'b1;
                if (confirm_edge) begin
                    read_data_d = bus.in_data;
                    state_d     = S_DONE;
                end
            end
            S_WAIT_KEY: begin
                stall = 1'b1;
                if (bus.key_valid) begin
                    read_data_d = DATA_WIDTH'(bus.key_data);
                    key_ack     = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_WAIT_DISP: begin
                stall    = 1'b1;
                disp_req = 1'b1;
                // An acknowledge on the last allowed cycle still counts as success.
                if (bus.disp_ack) begin
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(DISP_TIMEOUT)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                read_valid = rd_op_q;
                state_d    = S_IDLE;
            end
            S_HALTED: begin
                stall  = 1'b1;
                halted = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.stall       = stall;
    assign bus.read_data   = read_data_q;
    assign bus.read_valid  = read_valid;
    assign bus.halted      = halted;
    assign bus.timeout_err = timeout_err_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid;
    assign bus.key_ack     = key_ack;
    assign bus.disp_data   = disp_data_q;
    assign bus.disp_req    = disp_req;
endmodule

// File: tb/tb_io_sequencer.sv
// Purpose: self-checking bench for io_sequencer with a scoreboard of expected device/writeback events.
// Latency: n/a.
// Backpressure: n/a; device models answer with directed timing.
module tb_io_sequencer;
    localparam int DW = 32;
    localparam int TO = 4;
    localparam int EV_OUT  = 0;
    localparam int EV_READ = 1;
    localparam int EV_KEY  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    io_sequencer_if #(.DATA_WIDTH(DW)) bus();

    io_sequencer #(.DATA_WIDTH(DW), .DISP_TIMEOUT(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input int kind, input logic [31:0] data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d data 0x%0h, expected no event", kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data !== data) begin
                errors++;
                $display("FAIL event: got kind %0d data 0x%0h, expected kind %0d data 0x%0h",
                         kind, data, e.kind, e.data);
            end
        end
    endtask

    // Monitor: samples on the falling edge and matches every strobe against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.out_valid)  pop_check(EV_OUT, bus.out_data);
                if (bus.key_ack)    pop_check(EV_KEY, {24'h0, bus.key_data});
                if (bus.read_valid) pop_check(EV_READ, bus.read_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one IO instruction and counts stalled cycles and disp_req cycles until DONE.
    task automatic run_op(input logic [1:0] sel, input logic [31:0] wd,
                          output int n_stall, output int n_req);
        bit done;
        done = 1'b0;
        n_stall = 0;
        n_req = 0;
        bus.io_sel = sel;
        bus.write_data = wd;
        bus.io_enable = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.disp_req) begin
                n_req++;
                check("disp_data_stable", bus.disp_data, wd);
            end
            if (!bus.stall) begin
                done = 1'b1;
                break;
            end
            n_stall++;
            @(posedge clk);
            #1;
            bus.io_enable = 1'b0;
        end
        bus.io_enable = 1'b0;
        check("op_completes", {31'h0, done}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ns, nr;
        bus.io_enable = 0; bus.io_sel = 0; bus.halt = 0; bus.write_data = 0;
        bus.in_data = 0; bus.in_confirm = 0; bus.key_data = 0; bus.key_valid = 0;
        bus.disp_ack = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_stall", {31'h0, bus.stall}, 0);
        check("rst_halted", {31'h0, bus.halted}, 0);
        check("rst_disp_req", {31'h0, bus.disp_req}, 0);
        check("rst_timeout_err", {31'h0, bus.timeout_err}, 0);
        check("rst_strobes", {29'h0, bus.out_valid, bus.read_valid, bus.key_ack}, 0);
        check("rst_read_data", bus.read_data, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_disp_data", bus.disp_data, 0);
        @(posedge clk); #1; rst = 1'b0;
        tick();

        // OUT: one strobe with 0x1234, two stalled cycles
        expect_ev(EV_OUT, 32'h1234);
        run_op(2'd0, 32'h1234, ns, nr);
        check("out_stall_cycles", ns, 2);
        tick();
        check("out_data_held", bus.out_data, 32'h1234);

        // IN: a press made in IDLE and still held on entry is not an edge
        bus.in_data = 32'h1111;
        bus.in_confirm = 1'b1;
        repeat (3) tick();
        expect_ev(EV_READ, 32'hABCD);
        fork
            run_op(2'd1, 32'h0, ns, nr);
            begin
                repeat (3) tick();
                bus.in_confirm = 1'b0;
                repeat (2) tick();
                bus.in_data = 32'hABCD;
                bus.in_confirm = 1'b1;
            end
        join
        check("in_stall_cycles", ns, 6);
        tick();
        bus.in_data = 32'h2222;
        tick();
        check("in_read_data_held", bus.read_data, 32'hABCD);
        bus.in_confirm = 1'b0;

        // GETC: key arrives 5 cycles after issue
        expect_ev(EV_KEY, 32'h41);
        expect_ev(EV_READ, 32'h41);
        bus.key_data = 8'h41;
        fork
            run_op(2'd2, 32'h0, ns, nr);
            begin
                repeat (5) tick();
                bus.key_valid = 1'b1;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (bus.key_ack) break;
                end
                tick();
                bus.key_valid = 1'b0;
            end
        join
        check("getc_stall_cycles", ns, 6);
        tick();

        // GETC with key already waiting: accepted on the first wait cycle
        expect_ev(EV_KEY, 32'h7A);
        expect_ev(EV_READ, 32'h7A);
        bus.key_data = 8'h7A;
        bus.key_valid = 1'b1;
        run_op(2'd2, 32'h0, ns, nr);
        bus.key_valid = 1'b0;
        check("getc_ready_stall_cycles", ns, 2);
        tick();

        // Display, early acknowledge on the second wait cycle
        fork
            run_op(2'd3, 32'h5555, ns, nr);
            begin
                repeat (2) tick();
                bus.disp_ack = 1'b1;
                tick();
                bus.disp_ack = 1'b0;
            end
        join
        check("disp_early_req_cycles", nr, 2);
        check("disp_early_stall_cycles", ns, 3);
        tick();

        // Display, acknowledge on the final counter cycle wins over timeout
        fork
            run_op(2'd3, 32'h6666, ns, nr);
            begin
                repeat (5) tick();
                bus.disp_ack = 1'b1;
                tick();
                bus.disp_ack = 1'b0;
            end
        join
        check("disp_lastack_req_cycles", nr, 5);
        check("disp_lastack_stall_cycles", ns, 6);
        check("disp_lastack_no_timeout", {31'h0, bus.timeout_err}, 0);
        tick();

        // Display timeout: 5 request cycles then sticky error
        run_op(2'd3, 32'hCAFE, ns, nr);
        check("disp_to_req_cycles", nr, 5);
        check("disp_to_stall_cycles", ns, 6);
        check("disp_to_err_set", {31'h0, bus.timeout_err}, 1);
        check("disp_to_req_low_done", {31'h0, bus.disp_req}, 0);
        tick();
        expect_ev(EV_OUT, 32'h9);
        run_op(2'd0, 32'h9, ns, nr);
        check("timeout_err_sticky", {31'h0, bus.timeout_err}, 1);
        tick();

        // Halt beats IO_Enable; IO requests are ignored once halted
        bus.halt = 1'b1;
        bus.io_enable = 1'b1;
        bus.io_sel = 2'd0;
        bus.write_data = 32'hDEAD;
        @(negedge clk);
        check("halt_idle_stall", {31'h0, bus.stall}, 1);
        tick();
        bus.halt = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("halted_flag", {31'h0, bus.halted}, 1);
        check("halted_stall", {31'h0, bus.stall}, 1);
        check("halted_out_data", bus.out_data, 32'h9);
        bus.io_enable = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("halt_rst_halted", {31'h0, bus.halted}, 0);
        check("halt_rst_stall", {31'h0, bus.stall}, 0);
        check("rst_clears_timeout_err", {31'h0, bus.timeout_err}, 0);
        tick();
        rst = 1'b0;
        tick();

        // Reset in the middle of a display wait drops disp_req at once
        bus.io_sel = 2'd3;
        bus.write_data = 32'h77;
        bus.io_enable = 1'b1;
        tick();
        bus.io_enable = 1'b0;
        tick();
        @(negedge clk);
        check("wait_disp_req", {31'h0, bus.disp_req}, 1);
        #2 rst = 1'b1;
        #1;
        check("disp_rst_req", {31'h0, bus.disp_req}, 0);
        check("disp_rst_stall", {31'h0, bus.stall}, 0);
        check("disp_rst_data", bus.disp_data, 0);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("post_rst_idle_stall", {31'h0, bus.stall}, 0);
        check("post_rst_idle_req", {31'h0, bus.disp_req}, 0);

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
